// File: rtl/stream_max_tracker_pkg.sv
// Shared types and defaults for the stream max tracker: FSM encoding and default sample width.
package stream_max_tracker_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : stream_max_tracker_pkg

// File: rtl/stream_max_tracker_nibble_gt.sv
// Unsigned WIDTH-bit strict greater-than comparator (gt_o = a_i > b_i).
module nibble_gt
  import stream_max_tracker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o
);

  assign gt_o = (a_i > b_i);

endmodule : nibble_gt

// File: rtl/stream_max_tracker.sv
// Tracks the maximum (and its first index) over a fixed window of samples; pulses done per window.
// Define STREAM_MAX_TRACKER_MIN_EN to also track the minimum and expose min_value/min_index.
module stream_max_tracker
  import stream_max_tracker_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int WINDOW = 8,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] max_value,
  output logic [CNT_W-1:0] max_index,
  output logic             done
`ifdef STREAM_MAX_TRACKER_MIN_EN
  ,
  output logic [WIDTH-1:0] min_value,
  output logic [CNT_W-1:0] min_index
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [CNT_W-1:0] run_idx_q, run_idx_d;
  logic [WIDTH-1:0] max_value_q;
  logic [CNT_W-1:0] max_index_q;

  logic accept;
  logic last;
  logic first;
  logic gt_max;

  // in_ready_q is high exactly in ACCUM, so it doubles as the state qualifier.
  assign accept = in_valid & in_ready_q;
  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == CNT_W'(WINDOW - 1));

  nibble_gt #(.WIDTH(WIDTH)) u_gt_max (
    .a_i  (in_data),
    .b_i  (run_max_q),
    .gt_o (gt_max)
  );

`ifdef STREAM_MAX_TRACKER_MIN_EN
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [CNT_W-1:0] run_min_idx_q, run_min_idx_d;
  logic [WIDTH-1:0] min_value_q;
  logic [CNT_W-1:0] min_index_q;
  logic             lt_min;

  // Operands swapped: running_min > sample means the sample is a new strict minimum.
  nibble_gt #(.WIDTH(WIDTH)) u_gt_min (
    .a_i  (run_min_q),
    .b_i  (in_data),
    .gt_o (lt_min)
  );

  always_comb begin
    run_min_d     = run_min_q;
    run_min_idx_d = run_min_idx_q;
    if (accept && (first || lt_min)) begin
      run_min_d     = in_data;
      run_min_idx_d = cnt_q;
    end
  end

  assign min_value = min_value_q;
  assign min_index = min_index_q;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    if (accept && (first || gt_max)) begin
      run_max_d = in_data;
      run_idx_d = cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      run_max_q     <= '0;
      run_idx_q     <= '0;
      max_value_q   <= '0;
      max_index_q   <= '0;
`ifdef STREAM_MAX_TRACKER_MIN_EN
      run_min_q     <= '0;
      run_min_idx_q <= '0;
      min_value_q   <= '0;
      min_index_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            run_max_q     <= run_max_d;
            run_idx_q     <= run_idx_d;
            cnt_q         <= cnt_q + 1'b1;
`ifdef STREAM_MAX_TRACKER_MIN_EN
            run_min_q     <= run_min_d;
            run_min_idx_q <= run_min_idx_d;
`endif
            // Results load from the next-state values so they are visible alongside done.
            if (last) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              max_value_q <= run_max_d;
              max_index_q <= run_idx_d;
`ifdef STREAM_MAX_TRACKER_MIN_EN
              min_value_q <= run_min_d;
              min_index_q <= run_min_idx_d;
`endif
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign max_value = max_value_q;
  assign max_index = max_index_q;

endmodule : stream_max_tracker

// File: tb/tb_stream_max_tracker.sv
// Self-checking bench for stream_max_tracker: directed windows plus randomized windows vs. a reference model.
module tb_stream_max_tracker;

  localparam int WIDTH  = 4;
  localparam int WINDOW = 8;
  localparam int CNT_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic [WIDTH-1:0] max_value;
  logic [CNT_W-1:0] max_index;
  logic             done;
`ifdef STREAM_MAX_TRACKER_MIN_EN
  logic [WIDTH-1:0] min_value;
  logic [CNT_W-1:0] min_index;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] win [WINDOW];
  logic [WIDTH-1:0] exp_max;
  logic [CNT_W-1:0] exp_max_idx;
  logic [WIDTH-1:0] exp_min;
  logic [CNT_W-1:0] exp_min_idx;

  stream_max_tracker #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .max_value (max_value),
    .max_index (max_index),
    .done      (done)
`ifdef STREAM_MAX_TRACKER_MIN_EN
    ,
    .min_value (min_value),
    .min_index (min_index)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: window maximum/minimum with the earliest index winning ties.
  function automatic void model();
    exp_max     = win[0];
    exp_max_idx = '0;
    exp_min     = win[0];
    exp_min_idx = '0;
    for (int i = 1; i < WINDOW; i++) begin
      if (win[i] > exp_max) begin
        exp_max     = win[i];
        exp_max_idx = CNT_W'(i);
      end
      if (win[i] < exp_min) begin
        exp_min     = win[i];
        exp_min_idx = CNT_W'(i);
      end
    end
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_max_value"}, max_value, exp_max);
    check({tag, "_max_index"}, max_index, exp_max_idx);
`ifdef STREAM_MAX_TRACKER_MIN_EN
    check({tag, "_min_value"}, min_value, exp_min);
    check({tag, "_min_index"}, min_index, exp_min_idx);
`endif
  endtask

  // stall < 0 selects a random 0..3 stall cycles before each sample.
  task automatic run_window(input int stall, input bit poke_accum, input bit poke_done);
    int gaps;
    start = 1'b1;
    step();
    start = 1'b0;
    check("accum_in_ready", in_ready, 1);
    check("accum_busy", busy, 1);
    check_results("hold_prev");
    for (int i = 0; i < WINDOW; i++) begin
      gaps = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        step();
        check("stall_in_ready", in_ready, 1);
        check("stall_busy", busy, 1);
        check("stall_done", done, 0);
      end
      in_valid = 1'b1;
      in_data  = win[i];
      start    = poke_accum && (i == 3);
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      if (i < WINDOW - 1) begin
        check("mid_done", done, 0);
        check("mid_busy", busy, 1);
      end
    end
    model();
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_in_ready", in_ready, 0);
    check_results("done");
    start    = poke_done;
    in_valid = 1'b1;
    step();
    start    = 1'b0;
    check("post_done", done, 0);
    check("post_in_ready", in_ready, 0);
    check("post_busy", busy, 0);
    in_valid = 1'b0;
    step();
    check("idle_in_ready", in_ready, 0);
    check("idle_done", done, 0);
    check_results("idle_hold");
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    exp_max = '0; exp_max_idx = '0; exp_min = '0; exp_min_idx = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_results("rst");

    // Basic window.
    win = '{3, 9, 2, 9, 15, 0, 15, 1};
    run_window(0, 1'b0, 1'b0);
    check("basic_max_const", max_value, 15);
    check("basic_idx_const", max_index, 4);
`ifdef STREAM_MAX_TRACKER_MIN_EN
    check("basic_min_const", min_value, 0);
    check("basic_min_idx_const", min_index, 5);
`endif

    // All ties, then maximum in the last slot.
    win = '{7, 7, 7, 7, 7, 7, 7, 7};
    run_window(0, 1'b0, 1'b0);
    check("ties_idx_const", max_index, 0);
    win = '{0, 0, 0, 0, 0, 0, 0, 5};
    run_window(0, 1'b0, 1'b0);
    check("last_idx_const", max_index, 7);

    // Stalls between every sample.
    win = '{3, 9, 2, 9, 15, 0, 15, 1};
    run_window(2, 1'b0, 1'b0);

    // Reset mid-window discards the partial window and clears outputs.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(4 + i);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_max = '0; exp_max_idx = '0; exp_min = '0; exp_min_idx = '0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check_results("midrst");
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      step();
      check("midrst_no_done", done, 0);
      check("midrst_idle_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    win = '{1, 14, 6, 14, 2, 13, 0, 8};
    run_window(1, 1'b0, 1'b0);

    // Start pokes during ACCUM and the DONE cycle are ignored.
    win = '{5, 2, 11, 11, 4, 12, 3, 12};
    run_window(0, 1'b1, 1'b1);

    // Randomized windows, some drawn from a narrow range to provoke ties.
    for (int w = 0; w < 25; w++) begin
      for (int i = 0; i < WINDOW; i++)
        win[i] = (w % 3 == 0) ? WIDTH'($urandom_range(0, 2)) : WIDTH'($urandom);
      run_window(-1, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule : tb_stream_max_tracker

// File: doc/stream_max_tracker.md
Name: stream_max_tracker

Overview:
- Sequential stage directly downstream of the team's 4-bit max/compare mux logic.
- Consumes a stream of 4-bit samples over a fixed window and reports the window maximum and the position where it first appeared.
- Sits between the operand source (switch or stream feeder) and the display/LED driver.
- Latches the result and pulses done once per window.

Parameters:
- WIDTH, 4: sample width in bits.
- WINDOW, 8: samples per window; legal range 2..255.
- CNT_W, 3: index/counter width; must satisfy 2^CNT_W >= WINDOW.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new window; honoured only in IDLE.
- in_valid  in  1  in_data holds a sample.
- in_data  in  WIDTH  sample value, unsigned.
- in_ready  out  1  block accepts a sample this cycle.
- busy  out  1  a window is in progress.
- max_value  out  WIDTH  latched maximum of the last completed window.
- max_index  out  CNT_W  position (0-based) of the first occurrence of max_value.
- done  out  1  one-cycle pulse when max_value/max_index update.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE. in_ready, busy, done, max_value, max_index, internal counter and running registers all 0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> ACCUM next cycle; counter cleared.
- ACCUM:
  - in_ready=1, busy=1.
  - A sample is accepted when in_valid & in_ready are both high.
  - Accepted sample at count 0: running_max<=sample, running_idx<=0.
  - Later accepted samples: update running max/idx only if the sample is strictly greater than running_max. Ties keep the earlier index.
  - Counter increments per accepted sample. Cycles with in_valid=0 are stalls: no state change.
  - Accepting sample number WINDOW-1 -> DONE next cycle.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, in_ready=0.
  - max_value/max_index load the running values on entry, so they are visible while done=1.
  - Then -> IDLE unconditionally.
- Latency: done asserts the cycle after the last sample is accepted.
- Output holding: max_value/max_index hold until the next DONE or rst; they are unaffected by the start of a new window.
- start while in ACCUM or DONE: ignored, no restart.
- rst mid-window: immediate return to IDLE on the next edge. Partial window discarded; outputs cleared to 0.
- Comparisons are unsigned, WIDTH bits. No overflow is possible: values are only copied, never summed.
- in_valid while in IDLE or DONE: sample not accepted (in_ready=0). The upstream stage holds the data.

Optional Feature:
- Macro: STREAM_MAX_TRACKER_MIN_EN.
- Defined:
  - Adds ports min_value (out, WIDTH) and min_index (out, CNT_W).
  - Tracked in parallel with the max: update on strictly less-than, earliest index on ties.
  - Latched and reset identically to the max outputs; same done pulse.
- Undefined: these ports and their logic are absent. Max behaviour is unchanged.

Decomposition:
- Shared package:
  - FSM state encoding constants: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - Default WIDTH=4.
- One natural sub-module: nibble_gt, an unsigned WIDTH-bit strict greater-than comparator.
  - Instantiated once for max.
  - With the min feature, instantiated a second time with operands swapped.

Test Plan:
- Basic max: rst, start, samples 3,9,2,9,15,0,15,1 with in_valid held high -> done pulses 1 cycle after the 8th sample; max_value=15, max_index=4.
- All ties: eight samples of 7 -> max_value=7, max_index=0. Then a second window 0,0,0,0,0,0,0,5 -> max_value=5, max_index=7.
- Stalls: same data as the basic test, with in_valid low for 2 cycles between each sample -> identical result. busy stays 1 throughout; in_ready=1 in every ACCUM cycle.
- Reset mid-window: 4 samples accepted, then rst for 1 cycle -> IDLE, outputs 0, no done pulse. A full new window afterwards reports correctly.
- Start ignored: start pulsed during ACCUM and during the DONE cycle -> no restart, no extra window; in_ready stays 0 after DONE until the next start in IDLE.
- Min variant (STREAM_MAX_TRACKER_MIN_EN defined): basic test data -> min_value=0, min_index=5; max outputs unchanged.
